// File: rtl/core_pkg.sv
// Shared core definitions: zero-register encoding and hazard-controller state type.
package core_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Enable-driven saturating up-counter with synchronous reset; updates on the edge ending an enabled cycle.
// Holds at all-ones once reached, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubble, whole-pipe hold on dmem_busy, IF/ID flush on taken branch.
// Control outputs are combinational (same-cycle); a branch seen during a memory stall is deferred to release.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       SrcA_RF,
  input  logic [4:0]       SrcB_RF,
  input  logic             UsesA_ID,
  input  logic             UsesB_ID,
  input  logic [4:0]       Rd_EX,
  input  logic             MemRead_EX,
  input  logic             BrTaken_ID,
  input  logic             dmem_busy,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Pipe_Hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic              br_pending_q, br_pending_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              lu;

  always_comb begin
    lu = MemRead_EX && (Rd_EX != XZR) &&
         ((UsesA_ID && (Rd_EX == SrcA_RF)) || (UsesB_ID && (Rd_EX == SrcB_RF)));
  end

  always_comb begin
    PC_Write      = 1'b1;
    IFID_Write    = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Bubble   = 1'b0;
    Pipe_Hold     = 1'b0;
    state_d       = state_q;
    br_pending_d  = br_pending_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (!reset) begin
      if (dmem_busy) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        Pipe_Hold  = 1'b1;
      end else if (lu) begin
        // Branch operand not ready under lu; ID re-evaluates the branch next cycle.
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end else if (BrTaken_ID || br_pending_q) begin
        IFID_Flush = 1'b1;
      end

      case (state_q)
        RUN: begin
          if (dmem_busy) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_busy) begin
            if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end
        end
        default: state_d = RUN;
      endcase

      if (dmem_busy && BrTaken_ID) begin
        br_pending_d = 1'b1;
      end else if (IFID_Flush) begin
        br_pending_d = 1'b0;
      end

      mem_timeout_d = mem_timeout_q || (dmem_busy && (wait_cnt_d == WAIT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      br_pending_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      br_pending_q  <= br_pending_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (!PC_Write),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (IFID_Flush),
    .cnt   (flush_count)
  );

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline stall/flush controller for the 5-stage AArch64 core; works alongside the forwarding unit at the ID/EX boundary.
- Detects load-use hazards that forwarding cannot cover and inserts a bubble.
- Holds the whole pipeline while data memory is busy, and flushes IF/ID on a taken branch resolved in ID.
- A branch taken during a memory stall is deferred until the stall releases. Stall and flush events are counted for performance monitoring.

Parameters:
- MAX_WAIT, 64: number of consecutive dmem_busy cycles after which mem_timeout is set.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SrcA_RF  input  5  Rn of the instruction in ID.
- SrcB_RF  input  5  Reg2Loc-selected second source in ID.
- UsesA_ID  input  1  ID instruction reads SrcA_RF.
- UsesB_ID  input  1  ID instruction reads SrcB_RF.
- Rd_EX  input  5  destination register of the instruction in EX.
- MemRead_EX  input  1  instruction in EX is a load.
- BrTaken_ID  input  1  taken branch resolved in ID this cycle.
- dmem_busy  input  1  data memory cannot complete the MEM-stage access this cycle.
- PC_Write  output  1  PC may update.
- IFID_Write  output  1  IF/ID register may load.
- IFID_Flush  output  1  IF/ID loads a NOP.
- IDEX_Bubble  output  1  ID/EX loads a NOP (control bits zeroed).
- Pipe_Hold  output  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- mem_timeout  output  1  sticky flag: memory wait exceeded MAX_WAIT.
- stall_cycles  output  CNT_W  saturating count of cycles in which PC_Write was 0.
- flush_count  output  CNT_W  saturating count of cycles in which IFID_Flush was 1.

Behaviour:
- Load-use hazard term: lu = MemRead_EX && Rd_EX != 31 && ((UsesA_ID && Rd_EX == SrcA_RF) || (UsesB_ID && Rd_EX == SrcB_RF)).
- State register with two states, RUN and MEM_WAIT, plus two registered flags: br_pending and wait_cnt (sized for MAX_WAIT).
- The control outputs PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble and Pipe_Hold are combinational from the inputs and state, so they act in the same cycle.
- Output priority, highest first: dmem_busy, then lu, then branch.
  - dmem_busy=1: PC_Write=0, IFID_Write=0, Pipe_Hold=1, IDEX_Bubble=0, IFID_Flush=0.
  - Else lu=1: PC_Write=0, IFID_Write=0, IDEX_Bubble=1. A simultaneous BrTaken_ID is ignored, because the branch operand is not ready and ID re-evaluates next cycle.
  - Else (BrTaken_ID or br_pending): IFID_Flush=1, PC_Write=1.
  - Else all enables are 1 and all flush/bubble/hold outputs are 0.
- RUN to MEM_WAIT when dmem_busy=1. In MEM_WAIT, wait_cnt increments each busy cycle, saturating at MAX_WAIT.
- MEM_WAIT to RUN on the first cycle with dmem_busy=0; wait_cnt clears. That release cycle applies the normal lu/branch rules.
- BrTaken_ID=1 while dmem_busy=1 sets br_pending. br_pending clears in the cycle IFID_Flush is asserted.
  - The deferred flush fires on the release cycle unless lu=1 in that cycle; if lu=1 it fires on the following non-lu cycle.
  - Only one pending branch is held; further BrTaken_ID pulses while br_pending=1 are absorbed.
- mem_timeout is set on the cycle wait_cnt reaches MAX_WAIT while busy. It is cleared only by reset.
- Counters increment on the clock edge that ends a qualifying cycle, saturate at all-ones and never wrap.
- Reset behaviour:
  - State returns to RUN; br_pending=0, wait_cnt=0, mem_timeout=0, both counters=0.
  - While reset=1 the outputs are PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, Pipe_Hold=0. The inputs are ignored.
  - A reset during MEM_WAIT discards br_pending.
- Rd_EX=31 (XZR) never causes a stall. Rd_EX matching an unused source never causes a stall.

Decomposition:
- Shared core package (core_pkg): XZR constant 5'd31 and the state enum {RUN, MEM_WAIT}.
- One natural sub-module: sat_counter (CNT_W-bit enable-driven saturating counter with synchronous reset), instantiated for stall_cycles and flush_count.

Test Plan:
- Load-use: LDUR X2 in EX (MemRead_EX=1, Rd_EX=2), ID reads SrcA_RF=2 with UsesA_ID=1 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next cycle (Rd_EX now the bubble) all enables 1; stall_cycles=1.
- XZR and unused source: Rd_EX=31 with MemRead_EX=1 and SrcA_RF=31 -> no stall. Rd_EX=5 matching SrcB_RF with UsesB_ID=0 -> no stall.
- Memory wait with branch: dmem_busy high 3 cycles, BrTaken_ID pulsed in busy cycle 2 -> Pipe_Hold=1 for 3 cycles; IFID_Flush=1 exactly on the release cycle; flush_count=1; stall_cycles=3.
- Lu beats deferred branch: on release, br_pending=1 and lu=1 -> release cycle has IDEX_Bubble=1 and IFID_Flush=0; next cycle has IFID_Flush=1.
- Timeout: dmem_busy held 70 cycles with MAX_WAIT=64 -> mem_timeout rises after busy cycle 64 and stays 1 after busy drops, until reset.
- Reset mid-wait and saturation: reset asserted in MEM_WAIT with br_pending=1 -> no flush after reset, counters read 0. Forcing stall_cycles to 16'hFFFF -> it remains 16'hFFFF on further stalls.
